// File: rtl/dm_port_arbiter_if.sv
// Bundle of both issue-pipeline DM ports plus the shared SRAM bus.
// slave = arbiter side; master = pipelines + SRAM side.
interface dm_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          flush;
    logic          p0_req;
    logic          p0_write;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req;
    logic          p1_write;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  flush,
        input  p0_req, p0_write, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_write, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output stall,
        output mem_addr, mem_wdata, mem_write,
        input  mem_rdata
    );

    modport master (
        output flush,
        output p0_req, p0_write, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_write, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  stall,
        input  mem_addr, mem_wdata, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Program-order arbiter sharing one sync-read DM SRAM between p0/p1; grant is same-cycle, load data 1 cycle later.
// Backpressure: a same-bundle conflict serves p0 first and raises stall for exactly one cycle while p1 waits.
module dm_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    dm_port_arbiter_if.slave    bus,
    output logic [CW-1:0]       conflict_cnt
);

    typedef enum logic {IDLE, SERVE_P1} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [DW-1:0] p0_hold_q, p0_hold_d;
    logic [DW-1:0] p1_hold_q, p1_hold_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic gnt0, gnt1, stall;
    logic rvalid0, rvalid1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            p0_hold_q <= '0;
            p1_hold_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            p0_hold_q <= p0_hold_d;
            p1_hold_q <= p1_hold_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: SERVE_P1 always lasts a single cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     if (!bus.flush && bus.p0_req && bus.p1_req) state_d = SERVE_P1;
            SERVE_P1: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic; rst gates grants so a pending p1 store never reaches memory during reset.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        stall = 1'b0;
        if (!rst && !bus.flush) begin
            case (state_q)
                IDLE: begin
                    if (bus.p0_req) begin
                        gnt0  = 1'b1;
                        stall = bus.p1_req;
                    end else if (bus.p1_req) begin
                        gnt1 = 1'b1;
                    end
                end
                SERVE_P1: gnt1 = bus.p1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        if (gnt0) begin
            bus.mem_addr  = bus.p0_addr;
            bus.mem_wdata = bus.p0_wdata;
            bus.mem_write = bus.p0_write;
        end else if (gnt1) begin
            bus.mem_addr  = bus.p1_addr;
            bus.mem_wdata = bus.p1_wdata;
            bus.mem_write = bus.p1_write;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (gnt0 && !bus.p0_write)      owner_d = OWN_P0;
        else if (gnt1 && !bus.p1_write) owner_d = OWN_P1;
    end

    // Returning data is not cancelled by flush: the SRAM read is already in flight.
    assign rvalid0 = !rst && (owner_q == OWN_P0);
    assign rvalid1 = !rst && (owner_q == OWN_P1);

    always_comb begin
        p0_hold_d = rvalid0 ? bus.mem_rdata : p0_hold_q;
        p1_hold_d = rvalid1 ? bus.mem_rdata : p1_hold_q;
    end

    // Only the IDLE two-request case stalls, so stall doubles as the conflict event.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) cnt_d = cnt_q + CW'(1);
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.stall     = stall;
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rvalid0 ? bus.mem_rdata : p0_hold_q;
    assign bus.p1_rdata  = rvalid1 ? bus.mem_rdata : p1_hold_q;
    assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural sync-read SRAM; CW=4 to reach saturation.
module tb_dm_port_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] conflict_cnt;

    dm_port_arbiter_if #(.AW(9), .DW(16)) bus ();

    dm_port_arbiter #(.AW(9), .DW(16), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:511];
    bit          mem_init_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read SRAM; preloaded on the first edge, while reset is held.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'h0000;
            mem[9'h010]   <= 16'h1234;
            mem[9'h020]   <= 16'hAAAA;
            mem[9'h021]   <= 16'h5555;
            mem[9'h040]   <= 16'h7777;
            mem_init_done <= 1'b1;
            bus.mem_rdata <= 16'h0000;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_p0(input logic req, input logic wr, input logic [8:0] a, input logic [15:0] d);
        bus.p0_req = req; bus.p0_write = wr; bus.p0_addr = a; bus.p0_wdata = d;
    endtask

    task automatic drive_p1(input logic req, input logic wr, input logic [8:0] a, input logic [15:0] d);
        bus.p1_req = req; bus.p1_write = wr; bus.p1_addr = a; bus.p1_wdata = d;
    endtask

    task automatic load_conflict(input logic [8:0] a0, input logic [8:0] a1);
        next_cycle();
        drive_p0(1'b1, 1'b0, a0, 16'h0);
        drive_p1(1'b1, 1'b0, a1, 16'h0);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        next_cycle();
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        repeat (3) next_cycle();

        // Reset values
        rst = 1'b0;
        #1;
        check("rst_p0_gnt", bus.p0_gnt, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_p0_rvalid", bus.p0_rvalid, 0);
        check("rst_p1_rdata", bus.p1_rdata, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("idle_mem_addr", bus.mem_addr, 0);

        // p0 load only
        next_cycle();
        drive_p0(1'b1, 1'b0, 9'h010, 16'h0);
        #1;
        check("t1_p0_gnt", bus.p0_gnt, 1);
        check("t1_stall", bus.stall, 0);
        check("t1_mem_addr", bus.mem_addr, 9'h010);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t1_p0_rvalid", bus.p0_rvalid, 1);
        check("t1_p0_rdata", bus.p0_rdata, 16'h1234);
        check("t1_p1_rvalid", bus.p1_rvalid, 0);
        repeat (4) next_cycle();
        #1;
        check("t1_hold_rdata", bus.p0_rdata, 16'h1234);
        check("t1_hold_rvalid", bus.p0_rvalid, 0);

        // p1 load only
        next_cycle();
        drive_p1(1'b1, 1'b0, 9'h021, 16'h0);
        #1;
        check("p1only_gnt", bus.p1_gnt, 1);
        check("p1only_stall", bus.stall, 0);
        next_cycle();
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("p1only_rdata", bus.p1_rdata, 16'h5555);

        // Both loads in one bundle
        next_cycle();
        drive_p0(1'b1, 1'b0, 9'h020, 16'h0);
        drive_p1(1'b1, 1'b0, 9'h021, 16'h0);
        #1;
        check("t2_p0_gnt", bus.p0_gnt, 1);
        check("t2_p1_gnt_T", bus.p1_gnt, 0);
        check("t2_stall_T", bus.stall, 1);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t2_p1_gnt", bus.p1_gnt, 1);
        check("t2_stall_T1", bus.stall, 0);
        check("t2_mem_addr", bus.mem_addr, 9'h021);
        check("t2_p0_rdata", bus.p0_rdata, 16'hAAAA);
        check("t2_cnt", conflict_cnt, 1);
        next_cycle();
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t2_p1_rvalid", bus.p1_rvalid, 1);
        check("t2_p1_rdata", bus.p1_rdata, 16'h5555);
        check("t2_stall_T2", bus.stall, 0);

        // Same-bundle store then load to one address
        next_cycle();
        drive_p0(1'b1, 1'b1, 9'h030, 16'hBEEF);
        drive_p1(1'b1, 1'b0, 9'h030, 16'h0);
        #1;
        check("t3_mem_write", bus.mem_write, 1);
        check("t3_mem_wdata", bus.mem_wdata, 16'hBEEF);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t3_p1_gnt", bus.p1_gnt, 1);
        check("t3_mem_write_T1", bus.mem_write, 0);
        check("t3_store_no_rvalid", bus.p0_rvalid, 0);
        next_cycle();
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t3_p1_rdata", bus.p1_rdata, 16'hBEEF);

        // Flush in IDLE with both requesting
        next_cycle();
        bus.flush = 1'b1;
        drive_p0(1'b1, 1'b0, 9'h010, 16'h0);
        drive_p1(1'b1, 1'b0, 9'h021, 16'h0);
        #1;
        check("fl_idle_p0_gnt", bus.p0_gnt, 0);
        check("fl_idle_stall", bus.stall, 0);
        next_cycle();
        bus.flush = 1'b0;
        #1;
        check("fl_idle_no_conflict", conflict_cnt, 2);

        // Flush during SERVE_P1 with a p1 store pending
        drive_p1(1'b1, 1'b1, 9'h050, 16'h1111);
        #1;
        check("t4_stall_T", bus.stall, 1);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        bus.flush = 1'b1;
        #1;
        check("t4_p1_gnt", bus.p1_gnt, 0);
        check("t4_mem_write", bus.mem_write, 0);
        check("t4_stall", bus.stall, 0);
        check("t4_p0_rvalid_kept", bus.p0_rvalid, 1);
        check("t4_p0_rdata", bus.p0_rdata, 16'h1234);
        next_cycle();
        bus.flush = 1'b0;
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        drive_p0(1'b1, 1'b0, 9'h021, 16'h0);
        #1;
        check("t4_back_idle", bus.p0_gnt, 1);
        check("t4_cnt", conflict_cnt, 3);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t4_mem_untouched", mem[9'h050], 16'h0000);

        // Saturation: 12 more reach 15, 4 beyond must stick (19 total)
        for (int i = 0; i < 12; i++) load_conflict(9'h010, 9'h020);
        #1;
        check("sat_at_max", conflict_cnt, 4'hF);
        for (int i = 0; i < 4; i++) load_conflict(9'h010, 9'h020);
        #1;
        check("sat_hold", conflict_cnt, 4'hF);

        // Reset asserted while in SERVE_P1 with a p1 store pending
        next_cycle();
        drive_p0(1'b1, 1'b0, 9'h020, 16'h0);
        drive_p1(1'b1, 1'b1, 9'h040, 16'hDEAD);
        #1;
        check("t6_stall_T", bus.stall, 1);
        next_cycle();
        drive_p0(1'b0, 1'b0, 9'h0, 16'h0);
        rst = 1'b1;
        #1;
        check("t6_rst_p1_gnt", bus.p1_gnt, 0);
        check("t6_rst_mem_write", bus.mem_write, 0);
        next_cycle();
        rst = 1'b0;
        drive_p1(1'b0, 1'b0, 9'h0, 16'h0);
        #1;
        check("t6_p0_gnt", bus.p0_gnt, 0);
        check("t6_p1_gnt", bus.p1_gnt, 0);
        check("t6_stall", bus.stall, 0);
        check("t6_p0_rvalid", bus.p0_rvalid, 0);
        check("t6_p1_rvalid", bus.p1_rvalid, 0);
        check("t6_p0_rdata", bus.p0_rdata, 0);
        check("t6_p1_rdata", bus.p1_rdata, 0);
        check("t6_cnt", conflict_cnt, 0);
        check("t6_mem_write", bus.mem_write, 0);
        check("t6_mem_unchanged", mem[9'h040], 16'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
